// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: conditions the raw lines, frames bytes and decodes E0/F0/E1 prefixes
// into the toggle-encoded 11-bit key event word. Optional parity enforcement: PS2_PARITY_CHECK_EN.
module ps2_key_rx #(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 24000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [10:0] ps2_key,
  output logic [7:0]  rx_byte,
  output logic        rx_stb,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Index 0 is the clock line, index 1 the data line; both see identical delay.
  logic [1:0] sync1, sync2, filt, filt_n;
  logic [7:0] fcnt   [2];
  logic [7:0] fcnt_n [2];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_n[i] = filt[i];
      fcnt_n[i] = '0;
      if (sync2[i] != filt[i]) begin
        if (fcnt[i] == 8'(FILT_LEN - 1)) filt_n[i] = sync2[i];
        else                             fcnt_n[i] = fcnt[i] + 8'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1   <= {ps2_dat, ps2_clk};
      sync2   <= sync1;
      filt    <= filt_n;
      fcnt[0] <= fcnt_n[0];
      fcnt[1] <= fcnt_n[1];
    end
  end

  logic fall, dat;
  assign fall = filt[0] & ~filt_n[0];
  assign dat  = filt[1];

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shreg, sh_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          parity_ok, frame_good, frame_bad;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_bit, par_n;
  assign parity_ok = ^{shreg, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_n    = state;
    bit_n      = bit_cnt;
    sh_n       = shreg;
    tmo_n      = '0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_n      = par_bit;
`endif
    case (state)
      IDLE: if (fall) begin
        if (!dat) begin
          state_n = DATA;
          bit_n   = '0;
        end else begin
          frame_bad = 1'b1;
        end
      end
      DATA: if (fall) begin
        sh_n[bit_cnt] = dat;
        bit_n         = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = PARITY;
      end
      PARITY: if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
        par_n   = dat;
`endif
        state_n = STOP;
      end
      STOP: if (fall) begin
        state_n = IDLE;
        if (dat && parity_ok) frame_good = 1'b1;
        else                  frame_bad  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // A frame in flight is abandoned when the clock stalls; a coincident edge takes priority.
    if (state != IDLE && !fall) begin
      if (tmo == TW'(TIMEOUT - 1)) begin
        state_n   = IDLE;
        frame_bad = 1'b1;
      end else begin
        tmo_n = tmo + 1'b1;
      end
    end
  end

  logic       ext, brk;
  logic [2:0] skip;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tmo     <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit <= 1'b0;
`endif
      ext     <= 1'b0;
      brk     <= 1'b0;
      skip    <= '0;
      ps2_key <= '0;
      rx_byte <= '0;
      rx_stb  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      shreg   <= sh_n;
      tmo     <= tmo_n;
`ifdef PS2_PARITY_CHECK_EN
      par_bit <= par_n;
`endif
      rx_stb  <= frame_good;
      err     <= frame_bad;
      if (frame_bad) begin
        ext  <= 1'b0;
        brk  <= 1'b0;
        skip <= '0;
      end else if (frame_good) begin
        rx_byte <= shreg;
        if (skip != 3'd0) begin
          skip <= skip - 3'd1;
        end else begin
          case (shreg)
            8'hE0:   ext  <= 1'b1;
            8'hF0:   brk  <= 1'b1;
            8'hE1:   skip <= 3'd7;
            default: begin
              ps2_key <= {~ps2_key[10], ~brk, ext, shreg};
              ext     <= 1'b0;
              brk     <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench for ps2_key_rx: a byte-level prefix model predicts every rx_stb/ps2_key
// update and error count, with literal key values pinning the model at each scenario.
`timescale 1ns/1ps
module tb_ps2_key_rx;

  localparam int FILT_LEN = 8;
  localparam int TIMEOUT  = 400;
  localparam int HALF     = 40;   // 1 MHz clk_sys -> 12.5 kHz PS/2 clock

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] ps2_key;
  logic [7:0]  rx_byte;
  logic        rx_stb;
  logic        err;

  ps2_key_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .ps2_key (ps2_key),
    .rx_byte (rx_byte),
    .rx_stb  (rx_stb),
    .err     (err)
  );

  always #500 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]  b;
    logic [10:0] key;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   stb_cnt = 0;
  int   err_seen = 0;
  int   err_exp = 0;
  exp_t exp_q[$];

  // Model state: prefix flags, pause skip count and the last emitted key word.
  logic        m_ext = 1'b0;
  logic        m_brk = 1'b0;
  int          m_skip = 0;
  logic [10:0] m_key = '0;
  logic [10:0] cur_key = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      err_exp++;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_skip = 0;
    end else begin
      if (m_skip > 0)      m_skip--;
      else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE1) m_skip = 7;
      else begin
        m_key = {~m_key[10], ~m_brk, m_ext, b};
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
      exp_q.push_back('{b: b, key: m_key});
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk_sys) ps2_dat = b;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    bit   good;
    par = ~(^b) ^ bad_par;
`ifdef PS2_PARITY_CHECK_EN
    good = !bad_par;
`else
    good = 1'b1;
`endif
    model_frame(b, good);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    repeat (20) @(negedge clk_sys);
  endtask

  // Compare process: every stb must match the next model entry; key must hold otherwise.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      cur_key = '0;
    end else begin
      if (rx_stb) begin
        stb_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_stb", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rx_byte", rx_byte, e.b);
          check("ps2_key_on_stb", ps2_key, e.key);
          cur_key = e.key;
        end
      end else begin
        check("ps2_key_hold", ps2_key, cur_key);
      end
      if (err) err_seen++;
    end
  end

  int s0, e0;
  logic [10:0] k0;

  initial begin
    repeat (5) @(negedge clk_sys);
    check("rst_ps2_key", ps2_key, 0);
    check("rst_rx_byte", rx_byte, 0);
    check("rst_rx_stb", rx_stb, 0);
    check("rst_err", err, 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_sys);

    // Make code 0x1C
    s0 = stb_cnt;
    send_frame(8'h1C, 1'b0);
    check("make_key", ps2_key, 11'h61C);
    check("make_stb_cnt", stb_cnt - s0, 1);
    check("make_err_cnt", err_seen, 0);

    // Extended break E0 F0 75
    s0 = stb_cnt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("extbrk_key", ps2_key, 11'h175);
    check("extbrk_stb_cnt", stb_cnt - s0, 3);

    // Bad parity followed by good 0x29
    send_frame(8'h29, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("badpar_key_kept", ps2_key, 11'h175);
    check("badpar_err", err_seen, 1);
`else
    check("badpar_key_emitted", ps2_key, 11'h629);
    check("badpar_no_err", err_seen, 0);
`endif
    send_frame(8'h29, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("goodpar_key", ps2_key, 11'h629);
`else
    check("goodpar_key", ps2_key, 11'h229);
`endif

    // Timeout: start plus 4 data bits, then a stalled clock
    e0 = err_seen;
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    err_exp++;
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    repeat (TIMEOUT + 10) @(negedge clk_sys);
    check("timeout_err", err_seen - e0, 1);
    send_frame(8'h16, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("after_timeout_key", ps2_key, 11'h216);
`else
    check("after_timeout_key", ps2_key, 11'h616);
`endif

    // Glitch: 3-cycle low pulse on the clock line must be ignored
    s0 = stb_cnt; e0 = err_seen; k0 = m_key;
    @(negedge clk_sys) ps2_clk = 1'b0;
    repeat (3) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk_sys);
    send_frame(8'h1C, 1'b0);
    check("glitch_stb_cnt", stb_cnt - s0, 1);
    check("glitch_err_cnt", err_seen - e0, 0);
    check("glitch_key", ps2_key, {~k0[10], 10'h21C});

    // Pause sequence: eight bytes, no events
    s0 = stb_cnt; k0 = m_key;
    send_frame(8'hE1, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(8'h77, 1'b0);
    send_frame(8'hE1, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h77, 1'b0);
    check("pause_stb_cnt", stb_cnt - s0, 8);
    check("pause_key_kept", ps2_key, k0);
    send_frame(8'h5A, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("after_pause_key", ps2_key, 11'h25A);
`else
    check("after_pause_key", ps2_key, 11'h65A);
`endif

    // Reset in the middle of a frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge clk_sys) ps2_dat = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (HALF / 2) @(negedge clk_sys);
    reset_n = 1'b0;
    @(posedge clk_sys);
    #1;
    check("midrst_ps2_key", ps2_key, 0);
    check("midrst_rx_byte", rx_byte, 0);
    check("midrst_rx_stb", rx_stb, 0);
    check("midrst_err", err, 0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    exp_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; m_key = '0;
    err_seen = 0; err_exp = 0;
    repeat (20) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_sys);
    s0 = stb_cnt;
    send_frame(8'h1C, 1'b0);
    check("post_rst_key", ps2_key, 11'h61C);
    check("post_rst_stb_cnt", stb_cnt - s0, 1);

    check("err_total", err_seen, err_exp);
    check("stb_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_rx.md
# ps2_key_rx

Receives the raw PS/2 keyboard serial stream and produces the 11-bit toggle-encoded key event word `{toggle, pressed, extended, code[7:0]}` that core top levels consume. Core top-level key decoders watch bit 10 for change and `casex` on bits 8:0. The block sits between the keyboard pins and that decoder, in the `clk_sys` domain. It handles bit framing, the E0/F0 prefixes, and error recovery.

## Interface
- `FILT_LEN`, default 8: `clk_sys` cycles a synchronized line level must hold before the filtered level changes (1–255).
- `TIMEOUT`, default 24000: `clk_sys` cycles without a filtered PS/2 clock falling edge before a partial frame is abandoned.
- `clk_sys` input, 1 bit: system clock; all logic on its rising edge.
- `reset_n` input, 1 bit: synchronous reset, active-low.
- `ps2_clk` input, 1 bit: asynchronous PS/2 clock line.
- `ps2_dat` input, 1 bit: asynchronous PS/2 data line.
- `ps2_key` output, 11 bits: event word. Bit 10 toggles once per event, bit 9 is pressed (1 = make), bit 8 is extended (E0 seen), bits 7:0 are the scan code.
- `rx_byte` output, 8 bits: last good frame byte, including prefixes.
- `rx_stb` output, 1 bit: one-cycle pulse when `rx_byte` updates.
- `err` output, 1 bit: one-cycle pulse on a framing, parity or timeout error.

## Operation
- **Input conditioning:**
  - Each line passes through a 2-FF synchronizer, then a filter counter.
  - The filtered level changes only after `FILT_LEN` consecutive cycles of the opposite synchronized level.
  - A falling edge is filtered-clk going 1→0.
- **Frame FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge, sample data. 0 → DATA with bit count 0. 1 → stay in IDLE and pulse `err`.
  - DATA: on each falling edge, shift data into bit `cnt` (LSB first). After the 8th bit → PARITY.
  - PARITY: on a falling edge, store the parity bit → STOP.
  - STOP: on a falling edge, data must be 1 and parity must be good (XOR of 8 data bits and parity = 1).
    - Good: `rx_byte` loads, `rx_stb` pulses, the byte goes to the decoder, → IDLE.
    - Bad: `err` pulses, the byte is discarded, prefix flags clear, → IDLE.
  - Timeout counter resets on every falling edge and in IDLE.
  - Reaching `TIMEOUT` in DATA, PARITY or STOP: → IDLE, `err` pulses, prefix flags clear.
- **Prefix decoder**, running on each good byte:
  - E0: set `ext`. No event.
  - F0: set `brk`. No event.
  - E1: load the skip counter with 7. The next 7 good bytes are consumed silently, with no events and no flag changes.
  - Any other byte: `ps2_key <= {~ps2_key[10], ~brk, ext, byte}`, then clear `ext` and `brk`.
  - An F0 while `brk` is already set keeps `brk` set.
- **Error and timeout** also clear the skip counter.

## Timing
- **Reset values:** `ps2_key` = 0, `rx_byte` = 0, `rx_stb` = 0, `err` = 0. FSM is in IDLE, flags are clear, the filters' output level is 1, the skip counter is 0.
- **Reset mid-frame:** the partial frame is discarded and no event is produced.
- **Edge detection latency:** 2 + `FILT_LEN` cycles from the pin transition to the detected edge.
- **Byte latency:** `rx_byte`/`rx_stb` and `ps2_key` update on the clock edge following detection of the 11th falling edge. `ps2_key` and `rx_stb` change in the same cycle.
- **Pulse widths:** `rx_stb` and `err` are high for exactly one cycle per occurrence.
- **Data sampling:** `ps2_dat` is sampled as its filtered level in the cycle the clock edge is detected. The data line passes through the same filter depth, so skew between the two lines is preserved.
- **Timeout and edge in the same cycle:** the edge wins and the timeout counter resets.
- **Toggle behaviour:** bit 10 toggles exactly once per emitted event. Consumers detect events by comparing against the previous value.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: a parity mismatch in STOP causes discard plus `err`, as in Operation.
  - Undefined: the parity bit is sampled but ignored. Only the stop bit and timeout generate `err`.

## Test plan
- **Make code:** frame 0x1C (parity 0, stop 1) at a 12.5 kHz PS/2 clock → `ps2_key` = {1, 1, 0, 0x1C}, one `rx_stb`, no `err`.
- **Extended break:** E0, F0, 75 → only one event, `ps2_key[9:0]` = {0, 1, 0x75}, bit 10 toggled. Three `rx_stb` pulses.
- **Bad parity:** byte 0x29 with a bad parity bit.
  - Macro defined: `err` pulses, `ps2_key` unchanged. A following good 0x29 → event {press, 0x029}.
  - Macro undefined: the bad frame itself emits the event.
- **Timeout:** send start plus 4 data bits, then hold the clock high for `TIMEOUT` + 10 cycles → one `err`, FSM in IDLE. A next full 0x16 frame decodes correctly.
- **Glitch:** a 3-cycle low pulse on `ps2_clk` with `FILT_LEN` = 8 → no edge, no state change.
- **Pause sequence and reset:** E1 14 77 E1 F0 14 F0 77 → no events, 8 `rx_stb` pulses. A following 0x5A → event {press, 0x05A}. Asserting `reset_n` low mid-frame → all outputs 0 on the next cycle.
